// File: rtl/channel_accumulator.sv
// ---------------------------------------------------------------------------
// channel_accumulator
//
// Downstream stage of the 3x3 convolution adder tree. Each accepted input beat
// is one signed partial sum for one input channel. NUM_CHANNELS consecutive
// sums are added in a wide accumulator. The result is saturated to DATA_WIDTH
// and presented as one output pixel.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   clear      - synchronous abort of the partial accumulation
//   in_valid   - in_data is valid
//   in_ready   - block can accept in_data this cycle
//   in_data    - signed partial sum from the adder tree
//   out_valid  - out_data is valid
//   out_ready  - consumer accepts out_data this cycle
//   out_data   - saturated accumulated pixel
//   out_sat    - 1 when saturation was applied to out_data
//
// Optional feature:
//   CHANNEL_ACCUMULATOR_RELU_EN - when defined, ReLU is applied after
//   saturation. out_sat still reflects the pre-ReLU saturation.
// ---------------------------------------------------------------------------
module channel_accumulator #(
  parameter int DATA_WIDTH   = 16,
  parameter int ACC_WIDTH    = 32,
  parameter int NUM_CHANNELS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat
);

  localparam int CNT_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CHANNELS - 1);

  // Representable range of the output, expressed in accumulator width.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]      ch_cnt_q, ch_cnt_d;
  logic                         out_valid_q, out_valid_d;
  logic        [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                         out_sat_q, out_sat_d;

  logic                         in_beat;
  logic                         out_beat;
  logic                         is_final;
  logic signed [ACC_WIDTH-1:0]  in_ext;
  logic signed [ACC_WIDTH-1:0]  acc_base;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic        [DATA_WIDTH-1:0] sat_data;
  logic                         sat_flag;
  logic        [DATA_WIDTH-1:0] pixel;

  // A new beat is accepted whenever the output slot is empty or being drained.
  assign in_ready = !out_valid_q || out_ready;
  assign in_beat  = in_valid && in_ready;
  assign out_beat = out_valid_q && out_ready;
  assign is_final = (ch_cnt_q == LAST_CH);

  // Channel 0 starts a fresh sum, so the stale accumulator is ignored there.
  // With a single channel the count never leaves 0, which covers that case.
  assign in_ext   = ACC_WIDTH'($signed(in_data));
  assign acc_base = (ch_cnt_q == '0) ? '0 : acc_q;
  assign sum      = acc_base + in_ext;

  always_comb begin
    sat_flag = 1'b0;
    sat_data = sum[DATA_WIDTH-1:0];
    if (sum > SAT_MAX) begin
      sat_flag = 1'b1;
      sat_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (sum < SAT_MIN) begin
      sat_flag = 1'b1;
      sat_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

`ifdef CHANNEL_ACCUMULATOR_RELU_EN
  // Negative pixels are clamped to zero after saturation.
  assign pixel = sat_data[DATA_WIDTH-1] ? '0 : sat_data;
`else
  assign pixel = sat_data;
`endif

  // Clear only aborts the accumulation; a pending output is still drained
  // normally. A final beat coinciding with an output beat reloads the output
  // register so pixels can stream back to back.
  always_comb begin
    acc_d       = acc_q;
    ch_cnt_d    = ch_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (out_beat) begin
      out_valid_d = 1'b0;
    end
    if (clear) begin
      acc_d    = '0;
      ch_cnt_d = '0;
    end else if (in_beat) begin
      if (is_final) begin
        ch_cnt_d    = '0;
        out_valid_d = 1'b1;
        out_data_d  = pixel;
        out_sat_d   = sat_flag;
      end else begin
        acc_d    = sum;
        ch_cnt_d = ch_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      ch_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ch_cnt_q    <= ch_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_channel_accumulator.sv
// ---------------------------------------------------------------------------
// tb_channel_accumulator
//
// Directed bench for channel_accumulator (DATA_WIDTH=16, NUM_CHANNELS=3).
// Inputs are driven 1 time unit after the rising edge, and outputs are
// sampled at the same point. Expected values for the negative results
// depend on CHANNEL_ACCUMULATOR_RELU_EN.
// ---------------------------------------------------------------------------
module tb_channel_accumulator;

   logic        clk;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_sat;

   int vectorCount = 0;
   int missCount   = 0;

`ifdef CHANNEL_ACCUMULATOR_RELU_EN
   localparam logic [15:0] NEG_SAT_RESULT = 16'h0000;
   localparam logic [15:0] NEG35_RESULT   = 16'h0000;
   localparam logic [15:0] NEG3_RESULT    = 16'h0000;
`else
   localparam logic [15:0] NEG_SAT_RESULT = 16'h8000;
   localparam logic [15:0] NEG35_RESULT   = 16'hFFDD;
   localparam logic [15:0] NEG3_RESULT    = 16'hFFFD;
`endif

   channel_accumulator #(
      .DATA_WIDTH  (16),
      .ACC_WIDTH   (32),
      .NUM_CHANNELS(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_sat  (out_sat)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, then settle just past the next rising edge.
   task automatic applyStimulus(input logic valid, input logic [15:0] data,
                                input logic ready, input logic clr);
      in_valid  = valid;
      in_data   = data;
      out_ready = ready;
      clear     = clr;
      @(posedge clk);
      #1;
   endtask

   // Count one comparison and report it when it disagrees.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Feed three channel sums with out_ready held high.
   task automatic sendPixel(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c);
      applyStimulus(1'b1, a, 1'b1, 1'b0);
      applyStimulus(1'b1, b, 1'b1, 1'b0);
      applyStimulus(1'b1, c, 1'b1, 1'b0);
      in_valid = 1'b0;
   endtask

   // Main stimulus sequence.
   initial begin
      logic [15:0] streamData [0:3][0:2];
      logic [15:0] streamExp  [0:3];
      int          outSeen;

      streamData[0] = '{16'd1,   16'd1,   16'd1};
      streamData[1] = '{16'd2,   16'd2,   16'd2};
      streamData[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF};
      streamData[3] = '{16'd100, 16'd200, 16'd300};
      streamExp     = '{16'd3, 16'd6, NEG3_RESULT, 16'd600};

      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #12;
      checkOutput("reset_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_data",  32'(out_data),  32'd0);
      checkOutput("reset_sat",   32'(out_sat),   32'd0);
      checkOutput("reset_ready", 32'(in_ready),  32'd1);
      rst_n = 1'b1;

      sendPixel(16'd100, 16'hFFE2, 16'd5);
      checkOutput("basic_valid", 32'(out_valid), 32'd1);
      checkOutput("basic_data",  32'(out_data),  32'd75);
      checkOutput("basic_sat",   32'(out_sat),   32'd0);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("basic_drop",  32'(out_valid), 32'd0);
      checkOutput("basic_hold",  32'(out_data),  32'd75);

      sendPixel(16'd30000, 16'd30000, 16'd30000);
      checkOutput("satpos_data", 32'(out_data), 32'h7FFF);
      checkOutput("satpos_sat",  32'(out_sat),  32'd1);
      sendPixel(16'h8AD0, 16'h8AD0, 16'h8AD0);
      checkOutput("satneg_data", 32'(out_data), 32'(NEG_SAT_RESULT));
      checkOutput("satneg_sat",  32'(out_sat),  32'd1);

      sendPixel(16'd10, 16'hFFCE, 16'd5);
      checkOutput("relu_data", 32'(out_data), 32'(NEG35_RESULT));
      checkOutput("relu_sat",  32'(out_sat),  32'd0);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

      // Pixel A completes under backpressure, then B waits behind it.
      applyStimulus(1'b1, 16'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'd3, 1'b0, 1'b0);
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_data",  32'(out_data),  32'd6);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 16'd7, 1'b0, 1'b0);
         checkOutput("bp_hold_data",  32'(out_data),  32'd6);
         checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_hold_ready", 32'(in_ready),  32'd0);
      end
      applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
      checkOutput("bp_drain", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
      checkOutput("bp_b_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_b_data",  32'(out_data),  32'd21);

      // Four pixels streamed without gaps.
      outSeen = 0;
      for (int p = 0; p < 4; p++) begin
         for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, streamData[p][j], 1'b1, 1'b0);
            if (out_valid) outSeen++;
            if (j == 2) begin
               checkOutput("stream_valid", 32'(out_valid), 32'd1);
               checkOutput("stream_data",  32'(out_data),  32'(streamExp[p]));
            end else begin
               checkOutput("stream_gap", 32'(out_valid), 32'd0);
            end
         end
      end
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("stream_count", 32'(outSeen), 32'd4);

      // Asynchronous reset in the middle of a pixel.
      applyStimulus(1'b1, 16'd500, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd600, 1'b1, 1'b0);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_data",  32'(out_data),  32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sendPixel(16'd1, 16'd1, 16'd1);
      checkOutput("midrst_result", 32'(out_data), 32'd3);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);

      // Clear in the middle of a pixel, with an ignored beat of 999.
      applyStimulus(1'b1, 16'd500, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd600, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd999, 1'b1, 1'b1);
      checkOutput("clr_valid", 32'(out_valid), 32'd0);
      sendPixel(16'd1, 16'd1, 16'd1);
      checkOutput("clr_result", 32'(out_data), 32'd3);

      // Clear must leave a pending output intact.
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 16'd1, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'd2, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'd3, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
      checkOutput("clr_pend_valid", 32'(out_valid), 32'd1);
      checkOutput("clr_pend_data",  32'(out_data),  32'd6);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("clr_pend_drain", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
